// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, one quotient bit per clock.
// A start/done handshake returns quotient, remainder and a divide-by-zero flag.
// Optional macro DIV_SIGNED_EN: operands become two's complement, the result
// truncates toward zero and the sign fix-up is applied on entry to DONE.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] inDatA,
    input  logic [WIDTH-1:0] inDatB,
    output logic [WIDTH-1:0] outQuo,
    output logic [WIDTH-1:0] outRem,
    output logic             busy,
    output logic             done,
    output logic             divZero
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;      // partial remainder; always < divisor so WIDTH bits suffice
    logic [WIDTH-1:0] quo_r;      // dividend bits shift out at the top, quotient bits in at the bottom
    logic [WIDTH-1:0] div_r;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] quo_next_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] fin_quo_s;
    logic [WIDTH-1:0] fin_rem_s;

`ifdef DIV_SIGNED_EN
    logic neg_q_r;
    logic neg_r_r;

    function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Operand magnitudes and result sign fix-up for two's complement mode.
    always_comb begin
        a_mag_s   = inDatA[WIDTH-1] ? twos_neg(inDatA) : inDatA;
        b_mag_s   = inDatB[WIDTH-1] ? twos_neg(inDatB) : inDatB;
        fin_quo_s = neg_q_r ? twos_neg(quo_next_s) : quo_next_s;
        fin_rem_s = neg_r_r ? twos_neg(rem_next_s) : rem_next_s;
    end

    // Remember result signs at accept time; remainder follows the dividend.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (state_r == IDLE && start) begin
            neg_q_r <= inDatA[WIDTH-1] ^ inDatB[WIDTH-1];
            neg_r_r <= inDatA[WIDTH-1];
        end
    end
`else
    // Unsigned mode: operands and results pass straight through.
    always_comb begin
        a_mag_s   = inDatA;
        b_mag_s   = inDatB;
        fin_quo_s = quo_next_s;
        fin_rem_s = rem_next_s;
    end
`endif

    // One restoring step: the WIDTH+1-bit trial's top bit is the borrow.
    // On borrow the shifted value is < divisor, so its top bit is zero.
    always_comb begin
        shifted_s  = {rem_r, quo_r[WIDTH-1]};
        trial_s    = shifted_s - {1'b0, div_r};
        borrow_s   = trial_s[WIDTH];
        rem_next_s = borrow_s ? shifted_s[WIDTH-1:0] : trial_s[WIDTH-1:0];
        quo_next_s = {quo_r[WIDTH-2:0], ~borrow_s};
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (inDatB == '0) begin
                        state_s = DONE;
                    end else begin
                        state_s = CALC;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            CALC: begin
                if (cnt_r == '0) begin
                    state_s = DONE;
                end else begin
                    state_s = CALC;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath and registered outputs; results only change on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
            div_r   <= '0;
            outQuo  <= '0;
            outRem  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            divZero <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        div_r <= b_mag_s;
                        quo_r <= a_mag_s;
                        rem_r <= '0;
                        cnt_r <= CNT_W'(WIDTH - 1);
                        if (inDatB == '0) begin
                            outQuo  <= '1;
                            outRem  <= inDatA;
                            divZero <= 1'b1;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                        end else begin
                            busy <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_r <= rem_next_s;
                    quo_r <= quo_next_s;
                    if (cnt_r == '0) begin
                        outQuo  <= fin_quo_s;
                        outRem  <= fin_rem_s;
                        divZero <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r - 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
